// File: rtl/ic_pkg.sv
// rtl/ic_pkg.sv - shared interrupt controller constants
package ic_pkg;

    localparam int IC_NUM_IRQ = 4;

    localparam logic [31:0] IRQC_ADDR_ENABLE   = 32'd0;
    localparam logic [31:0] IRQC_ADDR_MODE     = 32'd1;
    localparam logic [31:0] IRQC_ADDR_POLARITY = 32'd2;
    localparam logic [31:0] IRQC_ADDR_STATUS   = 32'd3;

    // Sticky event flags live in the upper half of STATUS.
    localparam int IRQC_STICKY_LSB = 16;

    // Lines come out of reset in edge mode, disabled, active-high.
    localparam logic [15:0] IRQC_ENABLE_RST   = 16'h0000;
    localparam logic [15:0] IRQC_MODE_RST     = 16'hFFFF;
    localparam logic [15:0] IRQC_POLARITY_RST = 16'h0000;

endpackage

// File: rtl/irq_trigger_conditioner_if.sv
// rtl/irq_trigger_conditioner_if.sv - register bus for the trigger conditioner
interface irq_trigger_conditioner_if;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/irq_line_filter.sv
// rtl/irq_line_filter.sv - per-line synchroniser, glitch filter and rise detect
module irq_line_filter #(
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = $clog2(FILTER_CYCLES) + 1
) (
    input  logic pclk_i,
    input  logic rst_i,
    input  logic raw,
    input  logic pol,
    input  logic pol_load,
    input  logic pol_new,
    output logic filt,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             filt_d;
    logic [CNT_W-1:0] cnt;
    logic             v;

    assign v    = s2 ^ pol;
    assign rise = filt & ~filt_d;

    // Two-flop synchroniser, then accept a new level only after it has been
    // stable for FILTER_CYCLES cycles; any shorter deviation restarts the count.
    // A polarity change re-seeds filt and filt_d together so it cannot look
    // like an edge.
    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
            cnt    <= '0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            filt_d <= filt;
            if (pol_load) begin
                filt   <= s2 ^ pol_new;
                filt_d <= s2 ^ pol_new;
                cnt    <= '0;
            end else if (v == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= v;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/irq_trigger_conditioner.sv
// rtl/irq_trigger_conditioner.sv - conditions raw interrupt lines into clean triggers
module irq_trigger_conditioner
    import ic_pkg::*;
#(
    parameter int NUM_IRQ       = IC_NUM_IRQ,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = $clog2(FILTER_CYCLES) + 1
) (
    input  logic                       pclk_i,
    input  logic                       rst_i,
    irq_trigger_conditioner_if.slave   apb,
    input  logic [NUM_IRQ-1:0]         irq_raw_i,
    output logic [NUM_IRQ-1:0]         irq_trigger_o
);

    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] polarity;
    logic [NUM_IRQ-1:0] sticky;

    logic [NUM_IRQ-1:0] filt;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pol_load;
    logic [NUM_IRQ-1:0] pol_wdata;
    logic [NUM_IRQ-1:0] sticky_clr;
    logic [NUM_IRQ-1:0] trig_next;

    logic addr_mapped;
    logic wr;
    logic rd;
    logic wr_enable;
    logic wr_mode;
    logic wr_polarity;
    logic wr_status;
    logic unused_pwdata;

    assign addr_mapped = (apb.paddr <= IRQC_ADDR_STATUS);
    assign wr          = apb.psel & apb.penable & apb.pwrite & addr_mapped;
    assign rd          = apb.psel & ~apb.pwrite & addr_mapped;
    assign wr_enable   = wr & (apb.paddr == IRQC_ADDR_ENABLE);
    assign wr_mode     = wr & (apb.paddr == IRQC_ADDR_MODE);
    assign wr_polarity = wr & (apb.paddr == IRQC_ADDR_POLARITY);
    assign wr_status   = wr & (apb.paddr == IRQC_ADDR_STATUS);

    assign apb.pready    = 1'b1;
    assign apb.pslverr   = apb.psel & apb.penable & ~addr_mapped;
    assign unused_pwdata = ^apb.pwdata;

    assign pol_wdata  = apb.pwdata[NUM_IRQ-1:0];
    // Only lines whose polarity actually flips get re-seeded, so rewriting the
    // same value does not throw away an in-progress filter count.
    assign pol_load   = {NUM_IRQ{wr_polarity}} & (pol_wdata ^ polarity);
    assign sticky_clr = wr_status ? apb.pwdata[IRQC_STICKY_LSB +: NUM_IRQ] : '0;
    assign trig_next  = enable & ((mode & rise) | (~mode & filt));

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
        irq_line_filter #(
            .FILTER_CYCLES (FILTER_CYCLES),
            .CNT_W         (CNT_W)
        ) u_filter (
            .pclk_i   (pclk_i),
            .rst_i    (rst_i),
            .raw      (irq_raw_i[i]),
            .pol      (polarity[i]),
            .pol_load (pol_load[i]),
            .pol_new  (pol_wdata[i]),
            .filt     (filt[i]),
            .rise     (rise[i])
        );
    end

    // Config registers, registered triggers and sticky flags; a trigger
    // registering on the same edge as a W1C keeps its flag set.
    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            enable        <= IRQC_ENABLE_RST[NUM_IRQ-1:0];
            mode          <= IRQC_MODE_RST[NUM_IRQ-1:0];
            polarity      <= IRQC_POLARITY_RST[NUM_IRQ-1:0];
            sticky        <= '0;
            irq_trigger_o <= '0;
        end else begin
            if (wr_enable)   enable   <= apb.pwdata[NUM_IRQ-1:0];
            if (wr_mode)     mode     <= apb.pwdata[NUM_IRQ-1:0];
            if (wr_polarity) polarity <= pol_wdata;
            sticky        <= (sticky & ~sticky_clr) | trig_next;
            irq_trigger_o <= trig_next;
        end
    end

    // Read mux; idle bus and unmapped addresses read as zero.
    always_comb begin
        apb.prdata = '0;
        if (rd) begin
            case (apb.paddr)
                IRQC_ADDR_ENABLE:   apb.prdata[NUM_IRQ-1:0] = enable;
                IRQC_ADDR_MODE:     apb.prdata[NUM_IRQ-1:0] = mode;
                IRQC_ADDR_POLARITY: apb.prdata[NUM_IRQ-1:0] = polarity;
                IRQC_ADDR_STATUS: begin
                    apb.prdata[NUM_IRQ-1:0]                  = filt;
                    apb.prdata[IRQC_STICKY_LSB +: NUM_IRQ]   = sticky;
                end
                default:            apb.prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_trigger_conditioner.sv
// tb/tb_irq_trigger_conditioner.sv - directed self-checking bench
module tb_irq_trigger_conditioner;

    logic       pclk = 1'b0;
    logic       rst  = 1'b1;
    logic [3:0] irq_raw = 4'h0;
    logic [3:0] irq_trig;

    int checks = 0;
    int errors = 0;
    int hi_cnt [4] = '{default: 0};

    irq_trigger_conditioner_if apb_if ();

    irq_trigger_conditioner #(
        .NUM_IRQ       (4),
        .FILTER_CYCLES (4)
    ) u_dut (
        .pclk_i        (pclk),
        .rst_i         (rst),
        .apb           (apb_if),
        .irq_raw_i     (irq_raw),
        .irq_trigger_o (irq_trig)
    );

    always #5 pclk = ~pclk;

    // Count high cycles of each trigger output, sampled mid-cycle.
    always @(negedge pclk) begin
        for (int i = 0; i < 4; i++) begin
            if (irq_trig[i] === 1'b1) hi_cnt[i] = hi_cnt[i] + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        apb_if.psel    = 1'b1;
        apb_if.pwrite  = 1'b1;
        apb_if.penable = 1'b0;
        apb_if.paddr   = a;
        apb_if.pwdata  = d;
        tick(1);
        apb_if.penable = 1'b1;
        tick(1);
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
        apb_if.psel    = 1'b1;
        apb_if.pwrite  = 1'b0;
        apb_if.penable = 1'b1;
        apb_if.paddr   = a;
        #1;
        d   = apb_if.prdata;
        err = apb_if.pslverr;
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic e;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++; if (irq_trig !== 4'h0) begin errors++; $display("FAIL reset_trig got %h want 0", irq_trig); end
        checks++; if (apb_if.pready !== 1'b1) begin errors++; $display("FAIL pready got %b want 1", apb_if.pready); end
        apb_read(32'd0, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_enable got %h want 0", d); end
        apb_read(32'd1, d, e);
        checks++; if (d !== 32'hF) begin errors++; $display("FAIL reset_mode got %h want f", d); end
        apb_read(32'd2, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pol got %h want 0", d); end
        apb_read(32'd3, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", d); end
        checks++; if (apb_if.prdata !== 32'h0) begin errors++; $display("FAIL idle_prdata got %h want 0", apb_if.prdata); end
    endtask

    task automatic test_edge();
        logic [31:0] d;
        logic e;
        int b;
        apb_write(32'd0, 32'hF);
        b = hi_cnt[0];
        irq_raw[0] = 1'b1;
        tick(6);
        checks++; if (irq_trig[0] !== 1'b0) begin errors++; $display("FAIL edge_early got %b want 0", irq_trig[0]); end
        tick(1);
        checks++; if (irq_trig[0] !== 1'b1) begin errors++; $display("FAIL edge_k6 got %b want 1", irq_trig[0]); end
        apb_read(32'd3, d, e);
        checks++; if (d !== 32'h0001_0001) begin errors++; $display("FAIL edge_status got %h want 00010001", d); end
        tick(5);
        checks++; if (hi_cnt[0] - b !== 1) begin errors++; $display("FAIL edge_pulses got %0d want 1", hi_cnt[0] - b); end
        irq_raw[0] = 1'b0;
        tick(8);
        apb_write(32'd3, 32'h000F_0000);
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic e;
        int b;
        b = hi_cnt[1];
        irq_raw[1] = 1'b1;
        tick(3);
        irq_raw[1] = 1'b0;
        tick(8);
        checks++; if (hi_cnt[1] - b !== 0) begin errors++; $display("FAIL glitch3_pulses got %0d want 0", hi_cnt[1] - b); end
        apb_read(32'd3, d, e);
        checks++; if ((d & 32'h0002_0002) !== 32'h0) begin errors++; $display("FAIL glitch3_status got %h want 0", d & 32'h0002_0002); end
        irq_raw[1] = 1'b1;
        tick(4);
        irq_raw[1] = 1'b0;
        tick(10);
        checks++; if (hi_cnt[1] - b !== 1) begin errors++; $display("FAIL hold4_pulses got %0d want 1", hi_cnt[1] - b); end
        apb_read(32'd3, d, e);
        checks++; if ((d & 32'h0002_0002) !== 32'h0002_0000) begin errors++; $display("FAIL hold4_status got %h want 00020000", d & 32'h0002_0002); end
        apb_write(32'd3, 32'h000F_0000);
    endtask

    task automatic test_level();
        int b;
        apb_write(32'd1, 32'hB);
        b = hi_cnt[2];
        irq_raw[2] = 1'b1;
        tick(6);
        checks++; if (irq_trig[2] !== 1'b0) begin errors++; $display("FAIL level_early got %b want 0", irq_trig[2]); end
        tick(1);
        checks++; if (irq_trig[2] !== 1'b1) begin errors++; $display("FAIL level_k6 got %b want 1", irq_trig[2]); end
        tick(3);
        irq_raw[2] = 1'b0;
        tick(6);
        checks++; if (irq_trig[2] !== 1'b1) begin errors++; $display("FAIL level_hold got %b want 1", irq_trig[2]); end
        tick(1);
        checks++; if (irq_trig[2] !== 1'b0) begin errors++; $display("FAIL level_fall got %b want 0", irq_trig[2]); end
        checks++; if (hi_cnt[2] - b !== 10) begin errors++; $display("FAIL level_cycles got %0d want 10", hi_cnt[2] - b); end
        apb_write(32'd1, 32'hF);
        apb_write(32'd3, 32'h000F_0000);
    endtask

    task automatic test_polarity();
        logic [31:0] d;
        logic e;
        int b;
        irq_raw[3] = 1'b1;
        tick(10);
        b = hi_cnt[3];
        apb_write(32'd2, 32'h8);
        tick(8);
        checks++; if (hi_cnt[3] - b !== 0) begin errors++; $display("FAIL pol_write_pulses got %0d want 0", hi_cnt[3] - b); end
        apb_read(32'd3, d, e);
        checks++; if (d[3] !== 1'b0) begin errors++; $display("FAIL pol_filt_low got %b want 0", d[3]); end
        irq_raw[3] = 1'b0;
        tick(10);
        checks++; if (hi_cnt[3] - b !== 1) begin errors++; $display("FAIL pol_active_low got %0d want 1", hi_cnt[3] - b); end
        apb_read(32'd3, d, e);
        checks++; if (d[3] !== 1'b1) begin errors++; $display("FAIL pol_filt_high got %b want 1", d[3]); end
        apb_write(32'd2, 32'h0);
        tick(4);
        checks++; if (hi_cnt[3] - b !== 1) begin errors++; $display("FAIL pol_restore got %0d want 1", hi_cnt[3] - b); end
        apb_write(32'd3, 32'h000F_0000);
    endtask

    task automatic test_disable();
        logic [31:0] d;
        logic e;
        int b;
        apb_write(32'd0, 32'hE);
        b = hi_cnt[0];
        irq_raw[0] = 1'b1;
        tick(10);
        checks++; if (hi_cnt[0] - b !== 0) begin errors++; $display("FAIL disabled_pulses got %0d want 0", hi_cnt[0] - b); end
        apb_read(32'd3, d, e);
        checks++; if ((d & 32'h0001_0001) !== 32'h0000_0001) begin errors++; $display("FAIL disabled_status got %h want 00000001", d & 32'h0001_0001); end
        apb_write(32'd0, 32'hF);
        tick(3);
        checks++; if (hi_cnt[0] - b !== 0) begin errors++; $display("FAIL enable_late got %0d want 0", hi_cnt[0] - b); end
        irq_raw[0] = 1'b0;
        tick(8);
        irq_raw[0] = 1'b1;
        tick(5);
        apb_write(32'd3, 32'h0001_0000);
        tick(2);
        checks++; if (hi_cnt[0] - b !== 1) begin errors++; $display("FAIL w1c_race_pulses got %0d want 1", hi_cnt[0] - b); end
        apb_read(32'd3, d, e);
        checks++; if (d[16] !== 1'b1) begin errors++; $display("FAIL w1c_race_sticky got %b want 1", d[16]); end
        apb_write(32'd3, 32'h0001_0000);
        apb_read(32'd3, d, e);
        checks++; if (d[16] !== 1'b0) begin errors++; $display("FAIL w1c_clear got %b want 0", d[16]); end
        irq_raw[0] = 1'b0;
        tick(8);
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic e;
        apb_read(32'd5, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL unmapped_err got %b want 1", e); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_data got %h want 0", d); end
        apb_read(32'd0, d, e);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL mapped_err got %b want 0", e); end
        apb_write(32'd4, 32'h0);
        apb_read(32'd0, d, e);
        checks++; if (d !== 32'hF) begin errors++; $display("FAIL unmapped_write got %h want f", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic e;
        int b;
        b = hi_cnt[1];
        irq_raw[1] = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        checks++; if (irq_trig !== 4'h0) begin errors++; $display("FAIL midreset_trig got %h want 0", irq_trig); end
        rst = 1'b0;
        irq_raw[1] = 1'b0;
        apb_read(32'd0, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_enable got %h want 0", d); end
        apb_read(32'd3, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_status got %h want 0", d); end
        apb_write(32'd0, 32'hF);
        tick(10);
        checks++; if (hi_cnt[1] - b !== 0) begin errors++; $display("FAIL midreset_pulses got %0d want 0", hi_cnt[1] - b); end
    endtask

    initial begin
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = 1'b0;
        apb_if.paddr   = 32'h0;
        apb_if.pwdata  = 32'h0;
        test_reset();
        test_edge();
        test_glitch();
        test_level();
        test_polarity();
        test_disable();
        test_unmapped();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
